// File: rtl/keypad_scanner.sv
// Row-strobed keypad scanner: per-scan key detection, multi-scan debounce,
// registered key events and a 7-segment view of the last accepted key.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COLS-1:0]   column,
  output logic [ROWS-1:0]   row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_key,
  output logic [6:0]        display,
  output logic              common
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {C_NONE, C_SINGLE, C_MULTI} kind_e;
  typedef struct packed {
    kind_e             kind;
    logic [CODE_W-1:0] code;
  } cand_t;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1111110;  4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;  4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;  4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;  4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;  4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;  4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;  4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;  default: seg7 = 7'b1000111;
    endcase
  endfunction

  logic [COLS-1:0]   col_s1_q, col_s2_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic [1:0]        hits_q, hits_d;
  logic [CODE_W-1:0] first_q, first_d;
  cand_t             prev_q, prev_d;
  logic [3:0]        stable_q, stable_d;
  logic              eval_q, eval_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;
  logic [6:0]        display_q, display_d;

  logic              sample;
  logic [1:0]        row_hits, tot;
  logic [2:0]        sum3;
  logic [CODE_W-1:0] col_idx, row_code;
  cand_t             cand;

  always_comb begin
    cnt_d       = cnt_q;
    row_idx_d   = row_idx_q;
    hits_d      = hits_q;
    first_d     = first_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    eval_d      = 1'b0;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    display_d   = display_q;
    cand        = '{kind: C_NONE, code: '0};

    sample = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d  = sample ? '0 : cnt_q + 1'b1;

    // Saturating per-row hit count and lowest set column of this row.
    row_hits = 2'd0;
    col_idx  = '0;
    for (int i = COLS - 1; i >= 0; i--)
      if (col_s2_q[i]) col_idx = CODE_W'(i);
    for (int i = 0; i < COLS; i++)
      if (col_s2_q[i] && row_hits != 2'd2) row_hits = row_hits + 2'd1;
    row_code = CODE_W'(row_idx_q) * CODE_W'(COLS) + col_idx;
    sum3     = {1'b0, hits_q} + {1'b0, row_hits};
    tot      = (sum3 >= 3'd2) ? 2'd2 : sum3[1:0];

    if (sample) begin
      row_idx_d = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;
      if (row_idx_q == RW'(ROWS - 1)) begin
        case (tot)
          2'd0:    cand = '{kind: C_NONE,   code: '0};
          2'd1:    cand = '{kind: C_SINGLE, code: (hits_q == 2'd0) ? row_code : first_q};
          default: cand = '{kind: C_MULTI,  code: '0};
        endcase
        hits_d  = 2'd0;
        first_d = '0;
        if (cand == prev_q) begin
          if (stable_q < 4'(DEBOUNCE)) stable_d = stable_q + 4'd1;
        end else begin
          stable_d = 4'd1;
          prev_d   = cand;
        end
        eval_d = (stable_d == 4'(DEBOUNCE));
      end else begin
        hits_d  = tot;
        if (hits_q == 2'd0) first_d = row_code;
      end
    end

    // Acceptance runs the cycle after scan end on the stored stable candidate.
    if (eval_q) begin
      case (prev_q.kind)
        C_SINGLE: begin
          if (!key_held_q || prev_q.code != key_code_q) begin
            key_code_d  = prev_q.code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            multi_key_d = 1'b0;
            display_d   = seg7(4'(prev_q.code));
          end
        end
        C_MULTI: begin
          multi_key_d = 1'b1;
          key_held_d  = 1'b0;
        end
        default: begin
          key_held_d  = 1'b0;
          multi_key_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q    <= '0;
      col_s2_q    <= '0;
      cnt_q       <= '0;
      row_idx_q   <= '0;
      hits_q      <= 2'd0;
      first_q     <= '0;
      prev_q      <= '{kind: C_NONE, code: '0};
      stable_q    <= 4'd0;
      eval_q      <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
      display_q   <= 7'b0000000;
    end else begin
      col_s1_q    <= column;
      col_s2_q    <= col_s1_q;
      cnt_q       <= cnt_d;
      row_idx_q   <= row_idx_d;
      hits_q      <= hits_d;
      first_q     <= first_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      eval_q      <= eval_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
      display_q   <= display_d;
    end
  end

  assign row       = ROWS'(1) << row_idx_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;
  assign display   = display_q;
  assign common    = 1'b0;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised keypad bench: per-scan key-set model with debounce history,
// key events checked by a scoreboard monitor, levels and timing checked inline.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 3, SD = 4, DB = 2, CW = 4;
  localparam int NK = ROWS * COLS, SCAN = ROWS * SD;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [COLS-1:0] column = '0;
  logic [ROWS-1:0] row;
  logic [CW-1:0]   key_code;
  logic            key_valid, key_held, multi_key, common;
  logic [6:0]      display;

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .column(column), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key),
    .display(display), .common(common));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int exp_q[$];
  int hist[$];
  int m_code = 0;
  bit m_held = 0, m_multi = 0, m_valid = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seg(input int v);
    case (v & 15)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011; 10: return 7'b1110111; 11: return 7'b0011111;
      12: return 7'b1001110; 13: return 7'b0111101; 14: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [NK-1:0] key(input int k);
    logic [NK-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // -1 = no key, -2 = several keys, otherwise the single key's code.
  function automatic int cand_of(input logic [NK-1:0] keys);
    int n = 0, first = -1;
    for (int k = 0; k < NK; k++)
      if (keys[k]) begin
        n++;
        if (first < 0) first = k;
      end
    return (n == 0) ? -1 : (n == 1) ? first : -2;
  endfunction

  // Physical matrix: a pressed key connects its row strobe to its column.
  function automatic logic [COLS-1:0] col_of(input logic [NK-1:0] keys, input logic [ROWS-1:0] r);
    logic [COLS-1:0] c;
    c = '0;
    for (int k = 0; k < NK; k++)
      if (keys[k] && r[k / COLS]) c[k % COLS] = 1'b1;
    return c;
  endfunction

  task automatic model_scan(input logic [NK-1:0] keys);
    int c;
    bit stable;
    c = cand_of(keys);
    hist.push_back(c);
    if (hist.size() > DB) void'(hist.pop_front());
    stable = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] != c) stable = 0;
    m_valid = 0;
    if (stable) begin
      if (c >= 0) begin
        if (!m_held || c != m_code) begin
          m_code = c;
          m_valid = 1;
          exp_q.push_back(c);
        end
        m_held = 1;
        m_multi = 0;
      end else if (c == -1) begin
        m_held = 0;
        m_multi = 0;
      end else begin
        m_multi = 1;
        m_held = 0;
      end
    end
  endtask

  // One full scan with a fixed key set; optional noise away from sample instants.
  task automatic run_scan(input logic [NK-1:0] keys, input bit glitch);
    for (int j = 0; j < SCAN; j++) begin
      column = (glitch && (j % SD) != 1) ? COLS'($urandom) : col_of(keys, row);
      @(posedge clk);
      #1;
      if (j == 0) begin
        chk("key_valid", key_valid, m_valid);
        chk("key_held", key_held, m_held);
        chk("multi_key", multi_key, m_multi);
      end
      chk("row", row, 1 << (((j + 1) % SCAN) / SD));
    end
    model_scan(keys);
  endtask

  task automatic check_reset_vals();
    chk("rst_row", row, 1);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_multi_key", multi_key, 0);
    chk("rst_display", display, 0);
    chk("rst_common", common, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        int e;
        e = exp_q.pop_front();
        chk("ev_key_code", key_code, e);
        chk("ev_display", display, seg(e));
      end
    end
  end

  initial begin
    logic [NK-1:0] keys;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;

    repeat (4) run_scan(key(7), 0);
    chk("key7_display", display, 7'b1110000);
    repeat (3) run_scan('0, 0);
    chk("release_code_kept", key_code, 7);
    run_scan(key(0), 0);
    repeat (3) run_scan('0, 0);
    chk("short_press_code", key_code, 7);
    repeat (3) run_scan(key(0) | key(4), 0);
    repeat (3) run_scan(key(0), 0);
    repeat (2) run_scan('0, 0);
    repeat (3) run_scan(key(5), 1);
    chk("glitch_code", key_code, 5);
    repeat (2) run_scan('0, 0);

    for (int it = 0; it < 30; it++) begin
      int n, reps;
      bit g;
      n = $urandom_range(0, 2);
      keys = '0;
      for (int i = 0; i < n; i++) keys[$urandom_range(0, NK - 1)] = 1'b1;
      reps = $urandom_range(1, 3);
      g = 1'($urandom_range(0, 1));
      repeat (reps) run_scan(keys, g);
    end

    // Reset in the middle of row 2's dwell while a key is held.
    repeat (3) run_scan(key(7), 0);
    chk("pre_reset_held", key_held, 1);
    for (int j = 0; j < 9; j++) begin
      column = col_of(key(7), row);
      @(posedge clk);
      #1;
    end
    chk("pre_reset_row", row, 4'b0100);
    rst_n = 1'b0;
    #2;
    check_reset_vals();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist.delete();
    m_code = 0;
    m_held = 0;
    m_multi = 0;
    m_valid = 0;
    repeat (3) run_scan(key(7), 0);
    repeat (2) run_scan('0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
